// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone SDRAM initiator: FSM states, default
// widths and the SDRAM controller power-up window.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUS  = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

    localparam int WB_AW           = 24;
    localparam int WB_DW           = 32;
    localparam int WB_TIMEOUT      = 1024;
    // NOP, precharge, auto-refresh and mode-set window of the SDRAM controller.
    localparam int SDRAM_INIT_WAIT = 10100;

    // Width of a down-counter that must hold the larger of two preload values.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Loadable down-counter used for both the power-up wait and the bus timeout.
// It saturates at zero; load takes priority over decrement.
module wb_timeout_cnt #(
    parameter int CW      = 14,
    parameter int RST_VAL = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wb_sdram_master.sv
// Wishbone classic single-cycle initiator in front of the SDRAM controller.
// Waits out the controller power-up window and bounds every bus cycle with a timeout.
module wb_sdram_master
    import wb_pkg::*;
#(
    parameter int AW        = WB_AW,
    parameter int DW        = WB_DW,
    parameter int SW        = DW / 8,
    parameter int INIT_WAIT = SDRAM_INIT_WAIT,
    parameter int TIMEOUT   = WB_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [SW-1:0] req_sel,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          busy,
    output logic          proto_err,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [SW-1:0] wb_sel_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    localparam int CW = cnt_width(INIT_WAIT, TIMEOUT);

    wb_state_e     state_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_q;
    logic          busy_q;
    logic          proto_err_q;
    logic          cyc_q;
    logic          we_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [SW-1:0] sel_q;

    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic          cnt_zero;
    logic          slave_done;

    assign slave_done = wb_ack_i | wb_err_i;

    // The same counter paces the power-up wait and then times each bus cycle.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_INIT: cnt_dec = 1'b1;
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(TIMEOUT - 1);
                end
            end
            ST_BUS:  cnt_dec = ~slave_done;
            default: cnt_dec = 1'b0;
        endcase
    end

    wb_timeout_cnt #(
        .CW      (CW),
        .RST_VAL (INIT_WAIT - 1)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            // A response with no cycle open is a slave protocol violation.
            if (slave_done && !cyc_q) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                ST_INIT: begin
                    busy_q <= 1'b1;
                    if (cnt_zero) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q     <= ST_BUS;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        cyc_q       <= 1'b1;
                        we_q        <= req_we;
                        adr_q       <= req_addr;
                        dat_q       <= req_wdata;
                        sel_q       <= req_sel;
                    end
                end
                ST_BUS: begin
                    if (slave_done) begin
                        state_q     <= ST_RESP;
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= wb_err_i;
                        if (!we_q) begin
                            rsp_rdata_q <= wb_dat_i;
                        end
                    end else if (cnt_zero) begin
                        state_q     <= ST_RESP;
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign proto_err = proto_err_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;

endmodule

// File: tb/tb_wb_sdram_master.sv
// Directed bench for wb_sdram_master: power-up wait, write/read cycles,
// timeout, ack+err priority, stray acks and reset in mid-cycle.
module tb_wb_sdram_master;

    localparam int AW        = 24;
    localparam int DW        = 32;
    localparam int SW        = 4;
    localparam int INIT_WAIT = 10100;
    localparam int TIMEOUT   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_sel;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          proto_err;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;

    int n_checks = 0;
    int n_fail   = 0;

    wb_sdram_master #(
        .AW        (AW),
        .DW        (DW),
        .SW        (SW),
        .INIT_WAIT (INIT_WAIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .proto_err (proto_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{req_ready, rsp_valid, rsp_rdata, rsp_err, busy, proto_err,
                 wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
    endfunction

    // Called right after rst is dropped; counts edges until req_ready rises.
    task automatic wait_init(input string tag);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!req_ready && n < INIT_WAIT + 10) begin
            tick();
            n++;
            if (n == 1) check_eq({tag, "_busy_in_init"}, 64'(busy), 64'd1);
            if (wb_cyc_o || wb_stb_o || rsp_valid) seen = 1'b1;
        end
        check_eq({tag, "_wait_cycles"}, 64'(n), 64'(INIT_WAIT));
        check_eq({tag, "_no_bus_in_init"}, 64'(seen), 64'd0);
    endtask

    // Present one request while req_ready is high; returns after the accept edge
    // with the request inputs scrambled so only latched fields reach the bus.
    task automatic send_req(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_sel   = s;
        tick();
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~a;
        req_wdata = ~d;
        req_sel   = ~s;
    endtask

    task automatic check_bus(input string tag, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
        check_eq({tag, "_cyc_stb"}, 64'({wb_cyc_o, wb_stb_o}), 64'b11);
        check_eq({tag, "_we_adr_sel"}, 64'({wb_we_o, wb_adr_o, wb_sel_o}), 64'({we, a, s}));
        check_eq({tag, "_dat"}, 64'(wb_dat_o), 64'(d));
    endtask

    initial begin
        int   n;
        logic pe_seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_sel   = '0;
        wb_dat_i  = '0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;

        // 1: reset for 5 cycles, then the full power-up wait
        tick();
        check_eq("rst_outs_zero", 64'(any_out()), 64'd0);
        repeat (4) tick();
        check_eq("rst_outs_zero_end", 64'(any_out()), 64'd0);
        rst = 1'b0;
        wait_init("init1");
        check_eq("idle_busy", 64'(busy), 64'd0);

        // 2: write, slave acks in the 3rd bus cycle
        send_req(1'b1, 24'h000010, 32'hDEADBEEF, 4'hF);
        check_bus("wr_c1", 1'b1, 24'h000010, 32'hDEADBEEF, 4'hF);
        check_eq("wr_ready_low", 64'({req_ready, busy}), 64'b01);
        tick();
        check_bus("wr_c2", 1'b1, 24'h000010, 32'hDEADBEEF, 4'hF);
        tick();
        check_bus("wr_c3", 1'b1, 24'h000010, 32'hDEADBEEF, 4'hF);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check_eq("wr_resp", 64'({wb_cyc_o, wb_stb_o, rsp_valid, rsp_err}), 64'b0010);
        tick();
        check_eq("wr_after", 64'({rsp_valid, busy, req_ready}), 64'b001);

        // 3: read, ack in the first bus cycle
        send_req(1'b0, 24'h000010, 32'h0, 4'hF);
        check_bus("rd_c1", 1'b0, 24'h000010, 32'h0, 4'hF);
        wb_dat_i = 32'hDEADBEEF;
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        check_eq("rd_resp", 64'({wb_cyc_o, rsp_valid, rsp_err}), 64'b010);
        check_eq("rd_data", 64'(rsp_rdata), 64'hDEADBEEF);
        tick();
        check_eq("rd_after", 64'({rsp_valid, busy, req_ready}), 64'b001);

        // 4: silent slave on a read -> timeout after TIMEOUT bus cycles
        send_req(1'b0, 24'h0000A0, 32'h0, 4'h3);
        n = 0;
        while (wb_cyc_o && n < TIMEOUT + 8) begin
            n++;
            tick();
        end
        check_eq("to_bus_cycles", 64'(n), 64'(TIMEOUT));
        check_eq("to_resp", 64'({wb_stb_o, rsp_valid, rsp_err}), 64'b011);
        check_eq("to_rdata_held", 64'(rsp_rdata), 64'hDEADBEEF);
        tick();
        check_eq("to_ready_again", 64'({req_ready, rsp_valid}), 64'b10);
        send_req(1'b0, 24'h0000A4, 32'h0, 4'hF);
        check_eq("to_err_cleared", 64'({rsp_err, wb_cyc_o}), 64'b01);
        wb_dat_i = 32'hCAFE0001;
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check_eq("to_next_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), {32'h0, 2'b10, 32'hCAFE0001});
        tick();

        // 5a: ack and err together on a read -> error wins
        send_req(1'b0, 24'h000020, 32'h0, 4'hF);
        wb_dat_i = 32'h12345678;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check_eq("ackerr_resp", 64'({rsp_valid, rsp_err}), 64'b11);
        check_eq("ackerr_no_proto", 64'(proto_err), 64'd0);
        tick();

        // 5b: stray ack while idle -> sticky proto_err, no response
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check_eq("stray_proto", 64'({proto_err, rsp_valid, wb_cyc_o}), 64'b100);
        repeat (3) tick();
        check_eq("stray_sticky", 64'({proto_err, req_ready}), 64'b11);

        // 6: reset during the 2nd bus cycle of a write
        send_req(1'b1, 24'h000030, 32'hA5A5A5A5, 4'h5);
        tick();
        check_bus("rstmid_c2", 1'b1, 24'h000030, 32'hA5A5A5A5, 4'h5);
        rst = 1'b1;
        tick();
        check_eq("rstmid_outs_zero", 64'(any_out()), 64'd0);
        rst = 1'b0;
        pe_seen = 1'b0;
        wait_init("init2");
        check_eq("rstmid_proto_clear", 64'({proto_err, busy}), 64'b00);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
